// File: rtl/block_mem_responder.sv
// Block memory responder: fixed-latency 128-bit block store
// answering cache-side read/write requests with a ready pulse.
module block_mem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LOG2  = 6,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [27:0]            mem_addr,
    input  logic [BLOCK_WIDTH-1:0] mem_wdata,
    output logic [BLOCK_WIDTH-1:0] mem_rdata,
    output logic                   mem_ready,
    output logic                   busy,
    output logic                   proto_err
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_next;
    logic                   r_wr;
    logic [DEPTH_LOG2-1:0]  r_idx;
    logic [BLOCK_WIDTH-1:0] r_wdata;
    logic [BLOCK_WIDTH-1:0] r_rdata;
    logic                   r_perr;
    logic [BLOCK_WIDTH-1:0] r_store [0:DEPTH-1];

    logic                   w_accept;
    logic                   w_enter_resp;
    logic                   w_op_wr;
    logic [DEPTH_LOG2-1:0]  w_idx;
    logic [BLOCK_WIDTH-1:0] w_wd;
    logic                   w_unused;

    // Upper address bits alias away by design.
    assign w_unused = ^mem_addr[27:DEPTH_LOG2];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    w_accept   = 1'b1;
                    w_cnt_next = LAT_M1;
                    w_next     = (LATENCY > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // With LATENCY=1 the RESP entry edge is also the acceptance edge,
    // so the operands come straight from the ports in that case.
    assign w_op_wr      = w_accept ? mem_write : r_wr;
    assign w_idx        = w_accept ? mem_addr[DEPTH_LOG2-1:0] : r_idx;
    assign w_wd         = w_accept ? mem_wdata : r_wdata;
    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_wr    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_wr    <= mem_write;
                r_idx   <= mem_addr[DEPTH_LOG2-1:0];
                r_wdata <= mem_wdata;
                if (mem_read && mem_write) begin
                    r_perr <= 1'b1;
                end
            end
            if (w_enter_resp && !w_op_wr) begin
                r_rdata <= r_store[w_idx];
            end
        end
    end

    // Backing store is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && w_op_wr) begin
            r_store[w_idx] <= w_wd;
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_ready = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);
    assign proto_err = r_perr;

endmodule
